myo_spi_slave: RTL
==================

// Module: myo_spi_slave
// PURPOSE
//  SPI responder (motor-board end) for the myocontrol SPI master link: receives MOSI words and returns MISO words
//  within an ss_n-framed transaction. Used as a board-side FPGA endpoint and as a hardware-in-loop bench
//  partner for the myocontrol master. SPI mode 0 (CPOL=0, CPHA=0), MSB first, all SPI inputs oversampled in clk.
// PARAMETERS
//  WORD_W     16       bits per SPI word
//  MAX_WORDS  16       words per frame before rx_index wraps (power of 2)
//  IDLE_WORD  16'h0000 MISO word shifted when no tx word is held (underrun)
// PORTS
//  clk         in   1                  system clock; SCK must be <= clk/8
//  reset_n     in   1                  async active-low reset
//  sck_i       in   1                  SPI clock from master (async)
//  ss_n_i      in   1                  slave select, active low (async)
//  mosi_i      in   1                  master-out data (async)
//  miso_o      out  1                  slave-out data
//  miso_oe     out  1                  MISO drive enable (1 while selected)
//  tx_data     in   WORD_W             next word to return
//  tx_valid    in   1                  tx_data valid
//  tx_ready    out  1                  holding register empty; transfer on tx_valid&tx_ready
//  rx_data     out  WORD_W             last complete received word
//  rx_valid    out  1                  1-cycle pulse, rx_data/rx_index valid
//  rx_index    out  $clog2(MAX_WORDS)  word position in current frame
//  frame_done  out  1                  1-cycle pulse on clean ss_n rise (word boundary)
//  frame_err   out  1                  1-cycle pulse on ss_n rise mid-word
//  underrun    out  1                  1-cycle pulse when IDLE_WORD loaded for lack of tx data
// BEHAVIOUR
//  Reset: all outputs 0 except tx_ready=1; state IDLE; shifters, counters cleared; holding reg empty.
//  Sync: sck/ss_n/mosi each through 2-FF synchroniser + edge detect; edge events lag pins by 2-3 clk.
//  FSM IDLE: miso_oe=0, miso_o=0. On ss_n fall -> SHIFT; same cycle load tx shifter (holding reg if full,
//   else IDLE_WORD + underrun pulse), bit_cnt=0, rx_index=0, miso_oe=1, miso_o=shifter MSB.
//  SHIFT: sck rise -> rx_shift={rx_shift[W-2:0],mosi_s}, bit_cnt++. sck fall -> tx shifter shift left, miso_o=new MSB.
//   On rise completing bit WORD_W-1: rx_data<=assembled word, rx_valid pulse next cycle with rx_index of that
//   word; bit_cnt=0; following sck fall reloads tx shifter from holding reg (or IDLE_WORD+underrun) instead of shifting;
//   rx_index increments after the pulse, wraps MAX_WORDS-1 -> 0.
//  ss_n rise in SHIFT: bit_cnt==0 -> frame_done pulse; else frame_err pulse, partial word discarded (no rx_valid).
//   Either way -> IDLE, miso_oe=0 next cycle. ss_n fall and rise in same sync window impossible (>=2 clk apart).
//  sck edges while IDLE ignored. ss_n rise and final sck rise on same cycle: rx word completes first, then frame_done.
//  Holding reg: tx_ready=!full. Write when tx_valid&tx_ready; cleared on load into shifter; load and write same
//   cycle -> shifter takes old value, new value enters holding reg. Holding reg content survives across frames.
//  Async reset mid-frame: immediate return to reset values; no pulses emitted.
// STRUCTURE
//  myo_spi_pkg: WORD_W default, state enum {IDLE,SHIFT}, IDX_W function.
//  Sub-module spi_sync_edge: 2-FF synchroniser + rise/fall pulse outputs, instantiated for sck and ss_n
//  (mosi uses sync only). FSM, shifters, holding reg in top.
// TESTING
//  T1 preload tx 16'hA5C3, master sends 1 word 16'h1234 @clk/8 -> MISO reads 16'hA5C3, rx_data=16'h1234 idx0, frame_done.
//  T2 3-word frame 16'h0001,0002,0003, tx 16'hBEEF,CAFE,F00D pushed on tx_ready -> rx idx0..2 match, MISO matches.
//  T3 no tx data, 2-word frame -> MISO 16'h0000 twice, underrun pulses x2, rx still valid.
//  T4 ss_n released after 9 bits -> frame_err=1, no rx_valid, miso_oe=0, next frame rx_index=0.
//  T5 17-word frame with MAX_WORDS=16 -> rx_index 0..15 then 0; all words correct.
//  T6 reset_n low mid-word then frame 16'h5555 -> no stray pulses; clean frame decoded, tx_ready=1.

Source files
------------

// File: rtl/myo_spi_pkg.sv
// Shared types and helpers for the myocontrol SPI responder.
package myo_spi_pkg;

  localparam int DEFAULT_WORD_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Index width for a counter over n positions; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by single-cycle rise/fall event pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // [0] metastability catcher, [1] synchronised level, [2] previous level
  logic [2:0] pipe_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_reg <= {3{RESET_VAL}};
    end else begin
      pipe_reg <= {pipe_reg[1:0], d_i};
    end
  end

  assign rise_o = pipe_reg[1] & ~pipe_reg[2];
  assign fall_o = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/myo_spi_slave.sv
// SPI mode-0 responder for the myocontrol master link: ss_n-framed word exchange, MSB first,
// with a one-deep tx holding register and IDLE_WORD substitution on underrun.
module myo_spi_slave
  import myo_spi_pkg::*;
#(
  parameter int                WORD_W    = DEFAULT_WORD_W,
  parameter int                MAX_WORDS = 16,
  parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sck_i,
  input  logic                        ss_n_i,
  input  logic                        mosi_i,
  output logic                        miso_o,
  output logic                        miso_oe,
  input  logic [WORD_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [WORD_W-1:0]           rx_data,
  output logic                        rx_valid,
  output logic [idx_w(MAX_WORDS)-1:0] rx_index,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        underrun
);

  localparam int IDX_W = idx_w(MAX_WORDS);
  localparam int CNT_W = idx_w(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic mosi_meta_reg, mosi_s_reg;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (sck_i),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // ss_n idles high, so its synchroniser resets high to avoid a false frame start.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (ss_n_i),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0] rx_shift_reg, rx_shift_next;
  logic [WORD_W-1:0] tx_shift_reg, tx_shift_next;
  logic [WORD_W-1:0] hold_reg, hold_next;
  logic              hold_full_reg, hold_full_next;
  logic              reload_reg, reload_next;
  logic [WORD_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic [IDX_W-1:0]  rx_index_reg, rx_index_next;
  logic              frame_done_reg, frame_done_next;
  logic              frame_err_reg, frame_err_next;
  logic              underrun_reg, underrun_next;
  logic              load_tx;
  logic              hold_write;

  assign tx_ready   = ~hold_full_reg;
  assign hold_write = tx_valid & ~hold_full_reg;

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    rx_shift_next   = rx_shift_reg;
    tx_shift_next   = tx_shift_reg;
    reload_next     = reload_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    rx_index_next   = rx_index_reg;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;
    underrun_next   = 1'b0;
    load_tx         = 1'b0;

    // The index advances only after its word's pulse has been seen.
    if (rx_valid_reg) begin
      rx_index_next = rx_index_reg + IDX_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next    = SHIFT;
          load_tx       = 1'b1;
          bit_cnt_next  = '0;
          rx_index_next = '0;
          reload_next   = 1'b0;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          rx_shift_next = {rx_shift_reg[WORD_W-2:0], mosi_s_reg};
          if (bit_cnt_reg == LAST_BIT) begin
            rx_data_next  = {rx_shift_reg[WORD_W-2:0], mosi_s_reg};
            rx_valid_next = 1'b1;
            bit_cnt_next  = '0;
            reload_next   = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
        // The fall after a completed word fetches the next tx word instead of shifting.
        if (sck_fall) begin
          if (reload_reg) begin
            load_tx     = 1'b1;
            reload_next = 1'b0;
          end else begin
            tx_shift_next = {tx_shift_reg[WORD_W-2:0], 1'b0};
          end
        end
        // bit_cnt_next already reflects a word completing on this same cycle.
        if (ss_rise) begin
          state_next  = IDLE;
          reload_next = 1'b0;
          if (bit_cnt_next == '0) begin
            frame_done_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load_tx) begin
      tx_shift_next = hold_full_reg ? hold_reg : IDLE_WORD;
      underrun_next = ~hold_full_reg;
    end
  end

  // A load and a write can coincide only while empty: the shifter gets IDLE_WORD, the write is kept.
  always_comb begin
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    if (load_tx) begin
      hold_full_next = 1'b0;
    end
    if (hold_write) begin
      hold_next      = tx_data;
      hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      rx_shift_reg   <= '0;
      tx_shift_reg   <= '0;
      hold_reg       <= '0;
      hold_full_reg  <= 1'b0;
      reload_reg     <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_index_reg   <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      underrun_reg   <= 1'b0;
      mosi_meta_reg  <= 1'b0;
      mosi_s_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      rx_shift_reg   <= rx_shift_next;
      tx_shift_reg   <= tx_shift_next;
      hold_reg       <= hold_next;
      hold_full_reg  <= hold_full_next;
      reload_reg     <= reload_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      rx_index_reg   <= rx_index_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
      underrun_reg   <= underrun_next;
      mosi_meta_reg  <= mosi_i;
      mosi_s_reg     <= mosi_meta_reg;
    end
  end

  assign miso_oe    = (state_reg == SHIFT);
  assign miso_o     = miso_oe & tx_shift_reg[WORD_W-1];
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_index   = rx_index_reg;
  assign frame_done = frame_done_reg;
  assign frame_err  = frame_err_reg;
  assign underrun   = underrun_reg;

endmodule
